// File: rtl/exu_fpu_sched_if.sv
// FP scheduler bus: decode, FPU control, load return and writeback.
// The master modport is the scheduler's view.
interface exu_fpu_sched_if;
  logic        dec_valid;
  logic [4:0]  dec_rd;
  logic        dec_ready;
  logic        fpu_in_valid;
  logic        fpu_in_ready;
  logic        fpu_finish;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        fpu_flush;
  logic        flush_lower;
  logic        ld_wb_valid;
  logic [4:0]  ld_wb_rd;
  logic [31:0] ld_wb_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fflags_en;
  logic [4:0]  fflags;
  logic [31:0] sb_busy;
  logic        timeout_err;

  modport master (
    input  dec_valid, dec_rd, fpu_in_ready,
    input  fpu_finish, fpu_result, fpu_flags,
    input  flush_lower, ld_wb_valid,
    input  ld_wb_rd, ld_wb_data,
    output dec_ready, fpu_in_valid, fpu_flush,
    output wb_en, wb_rd, wb_data,
    output fflags_en, fflags, sb_busy,
    output timeout_err
  );

  modport slave (
    output dec_valid, dec_rd, fpu_in_ready,
    output fpu_finish, fpu_result, fpu_flags,
    output flush_lower, ld_wb_valid,
    output ld_wb_rd, ld_wb_data,
    input  dec_ready, fpu_in_valid, fpu_flush,
    input  wb_en, wb_rd, wb_data,
    input  fflags_en, fflags, sb_busy,
    input  timeout_err
  );
endinterface

// File: rtl/exu_fpu_sched.sv
// FP op scheduler: one op in flight to the FPU, flush/timeout kill,
// FP regfile write-port arbitration (loads win, FPU result buffered).
module exu_fpu_sched #(
  parameter int MAX_CYC = 64
) (
  input logic            clk,
  input logic            rst_l,
  exu_fpu_sched_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_EXEC, S_WBPEND
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(MAX_CYC - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [31:0] r_sb_busy;
  logic [31:0] r_buf_data;
  logic [4:0]  r_buf_flags;
  logic        r_wb_en;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_fflags_en;
  logic [4:0]  r_fflags;
  logic        r_timeout;

  logic        w_dec_ready;
  logic        w_in_valid;
  logic        w_fpu_flush;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout;
  logic        w_kill;
  logic        w_fpu_wb;
  logic        w_buf_load;
  logic [31:0] w_res;
  logic [4:0]  w_flags;

  // Next state and combinational handshake/kill decode.
  always_comb begin
    w_next      = r_state;
    w_dec_ready = 1'b0;
    w_in_valid  = 1'b0;
    w_fpu_flush = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_dec_ready = ~bus.flush_lower;
        if (bus.dec_valid && !bus.flush_lower) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.flush_lower) begin
          w_fpu_flush = 1'b1;
          w_next      = S_IDLE;
        end else begin
          w_in_valid = 1'b1;
          if (bus.fpu_in_ready) begin
            if (bus.fpu_finish) begin
              w_done = 1'b1;
              w_next = bus.ld_wb_valid ? S_WBPEND : S_IDLE;
            end else begin
              w_next = S_EXEC;
            end
          end
        end
      end
      S_EXEC: begin
        if (bus.flush_lower) begin
          w_fpu_flush = 1'b1;
          w_next      = S_IDLE;
        end else if (bus.fpu_finish) begin
          w_done = 1'b1;
          w_next = bus.ld_wb_valid ? S_WBPEND : S_IDLE;
        end else if (r_cnt == LP_LAST) begin
          w_timeout   = 1'b1;
          w_fpu_flush = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_WBPEND: begin
        if (bus.flush_lower || !bus.ld_wb_valid) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_kill = bus.flush_lower & (r_state != S_IDLE);
  assign w_buf_load = w_done & bus.ld_wb_valid;
  assign w_fpu_wb = ~bus.ld_wb_valid &
    (w_done | ((r_state == S_WBPEND) & ~bus.flush_lower));
  assign w_res = (r_state == S_WBPEND) ? r_buf_data : bus.fpu_result;
  assign w_flags = (r_state == S_WBPEND) ? r_buf_flags : bus.fpu_flags;

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // EXEC cycle counter, zero whenever the op is not staying in EXEC.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_cnt <= '0;
    else if (r_state == S_EXEC && w_next == S_EXEC) r_cnt <= r_cnt + 8'd1;
    else r_cnt <= '0;
  end

  // Pending rd scoreboard and one-entry result buffer.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rd        <= '0;
      r_sb_busy   <= '0;
      r_buf_data  <= '0;
      r_buf_flags <= '0;
    end else begin
      if (w_accept) begin
        r_rd      <= bus.dec_rd;
        r_sb_busy <= 32'(1) << bus.dec_rd;
      end else if (w_kill || w_timeout || w_fpu_wb) begin
        r_sb_busy <= '0;
      end
      if (w_buf_load) begin
        r_buf_data  <= bus.fpu_result;
        r_buf_flags <= bus.fpu_flags;
      end
    end
  end

  // Registered regfile write port: load return beats FPU result.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wb_en     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_fflags_en <= 1'b0;
      r_fflags    <= '0;
    end else begin
      r_wb_en     <= 1'b0;
      r_fflags_en <= 1'b0;
      if (bus.ld_wb_valid) begin
        r_wb_en   <= 1'b1;
        r_wb_rd   <= bus.ld_wb_rd;
        r_wb_data <= bus.ld_wb_data;
      end else if (w_fpu_wb) begin
        r_wb_en     <= 1'b1;
        r_wb_rd     <= r_rd;
        r_wb_data   <= w_res;
        r_fflags_en <= 1'b1;
        r_fflags    <= w_flags;
      end
    end
  end

  // Sticky watchdog error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)         r_timeout <= 1'b0;
    else if (w_timeout) r_timeout <= 1'b1;
  end

  assign bus.dec_ready    = w_dec_ready;
  assign bus.fpu_in_valid = w_in_valid;
  assign bus.fpu_flush    = w_fpu_flush;
  assign bus.wb_en        = r_wb_en;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_data      = r_wb_data;
  assign bus.fflags_en    = r_fflags_en;
  assign bus.fflags       = r_fflags;
  assign bus.sb_busy      = r_sb_busy;
  assign bus.timeout_err  = r_timeout;

endmodule
